// File: rtl/bsnn_lif_layer_if.sv
// Stream bundle for the binary spiking LIF layer: input vector in, per-step spikes out.
// No logic; widths follow the layer parameters.
// Producer/consumer valid-ready on both sides. The master side is the stimulus; the slave side is the layer.
interface bsnn_lif_layer_if #(
    parameter int WIDTH     = 8,
    parameter int N_NEURONS = 4,
    parameter int POT_W     = 8,
    parameter int T_STEPS   = 4,
    parameter int CNT_W     = $clog2(T_STEPS + 1)
);
    localparam int SIDX_W = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;

    logic                                  in_valid;
    logic                                  in_ready;
    logic [WIDTH-1:0]                      input_bits;
    logic [N_NEURONS-1:0][WIDTH-1:0]       weights;
    logic [POT_W-1:0]                      threshold;
    logic [POT_W-1:0]                      leak;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [N_NEURONS-1:0]                  spikes;
    logic [SIDX_W-1:0]                     step_idx;
    logic                                  out_last;
    logic [N_NEURONS-1:0][CNT_W-1:0]       spike_count;
    logic [N_NEURONS-1:0][POT_W-1:0]       membrane;

    modport master (
        output in_valid, input_bits, weights, threshold, leak, out_ready,
        input  in_ready, out_valid, spikes, step_idx, out_last, spike_count, membrane
    );

    modport slave (
        input  in_valid, input_bits, weights, threshold, leak, out_ready,
        output in_ready, out_valid, spikes, step_idx, out_last, spike_count, membrane
    );
endinterface

// File: rtl/bsnn_lif_layer.sv
// Binary spiking layer: XNOR-popcount per neuron, leaky integrate-and-fire over T_STEPS-step frames.
// Latency 2 cycles (popcount stage, integrate stage); 1 vector/cycle while out_ready is high.
// Whole pipeline freezes while out_valid && !out_ready; in_ready is just the advance enable.
module bsnn_lif_layer #(
    parameter int WIDTH      = 8,
    parameter int N_NEURONS  = 4,
    parameter int POT_W      = 8,
    parameter int T_STEPS    = 4,
    parameter int RESET_MODE = 0,
    parameter int CNT_W      = $clog2(T_STEPS + 1)
) (
    input logic             clk,
    input logic             rst,
    bsnn_lif_layer_if.slave io
);
    localparam int SIDX_W = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
    localparam int MW     = $clog2(WIDTH + 1);
    localparam logic [SIDX_W-1:0] LAST_STEP = SIDX_W'(T_STEPS - 1);

    logic                              adv;
    logic                              s1_vld;
    logic [N_NEURONS-1:0][MW-1:0]      s1_match;
    logic [N_NEURONS-1:0][MW-1:0]      match_c;
    logic [SIDX_W-1:0]                 step_cnt;
    logic [SIDX_W-1:0]                 step_q;
    logic                              out_vld_q;
    logic                              last_q;
    logic [N_NEURONS-1:0]              spk_q;
    logic [N_NEURONS-1:0]              spk_c;
    logic [N_NEURONS-1:0][CNT_W-1:0]   cnt_q;
    logic [N_NEURONS-1:0][CNT_W-1:0]   cnt_c;
    logic [N_NEURONS-1:0][POT_W-1:0]   mem_q;
    logic [N_NEURONS-1:0][POT_W-1:0]   mem_c;
    logic                              first_step;

    // Both stages move together whenever the output register is free or being drained.
    assign adv        = !out_vld_q || io.out_ready;
    assign io.in_ready = adv;
    assign first_step = (step_cnt == '0);

    assign io.out_valid   = out_vld_q;
    assign io.spikes      = spk_q;
    assign io.step_idx    = step_q;
    assign io.out_last    = last_q;
    assign io.spike_count = cnt_q;
    assign io.membrane    = mem_q;

    // Popcount of matching bits between the input vector and each neuron's weights.
    always_comb begin
        logic eq;
        eq      = 1'b0;
        match_c = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            for (int b = 0; b < WIDTH; b++) begin
                eq         = ~(io.input_bits[b] ^ io.weights[i][b]);
                match_c[i] = match_c[i] + MW'(eq);
            end
        end
    end

    // Stage 1 register: holds the match counts of the accepted vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_match <= '0;
        end else if (adv) begin
            s1_vld <= io.in_valid;
            if (io.in_valid) begin
                s1_match <= match_c;
            end
        end
    end

    // Integrate, leak, saturate, fire, then apply the post-spike action; step 0 starts from zero.
    always_comb begin
        logic [POT_W-1:0] prev_v;
        logic [POT_W-1:0] v_v;
        logic [POT_W:0]   sum_v;
        logic [POT_W:0]   lk_v;
        prev_v = '0;
        v_v    = '0;
        sum_v  = '0;
        lk_v   = '0;
        spk_c  = '0;
        mem_c  = '0;
        cnt_c  = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            prev_v   = first_step ? '0 : mem_q[i];
            sum_v    = {1'b0, prev_v} + (POT_W + 1)'(s1_match[i]);
            lk_v     = (sum_v > {1'b0, io.leak}) ? (sum_v - {1'b0, io.leak}) : '0;
            v_v      = lk_v[POT_W] ? '1 : lk_v[POT_W-1:0];
            spk_c[i] = (v_v >= io.threshold);
            if (spk_c[i]) begin
                mem_c[i] = (RESET_MODE != 0) ? '0 : (v_v - io.threshold);
            end else begin
                mem_c[i] = v_v;
            end
            cnt_c[i] = (first_step ? '0 : cnt_q[i]) + CNT_W'(spk_c[i]);
        end
    end

    // Stage 2 / output register and frame step counter; everything holds during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            spk_q     <= '0;
            step_q    <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            mem_q     <= '0;
            step_cnt  <= '0;
        end else if (adv) begin
            out_vld_q <= s1_vld;
            if (s1_vld) begin
                spk_q    <= spk_c;
                mem_q    <= mem_c;
                cnt_q    <= cnt_c;
                step_q   <= step_cnt;
                last_q   <= (step_cnt == LAST_STEP);
                step_cnt <= (step_cnt == LAST_STEP) ? '0 : step_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bsnn_lif_layer.sv
// Bench for bsnn_lif_layer: three instances (subtract reset, zero reset, 4-bit potential) driven in lockstep.
// Expected per-step results come from an integer reference model of the LIF rules.
// Exercises reset, leak, reset modes, saturation, backpressure, mid-frame reset and random frames.
module tb_bsnn_lif_layer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            iv;
    logic [7:0]      bits;
    logic            ordy;
    logic [3:0][7:0] w;
    logic [7:0]      thr;
    logic [7:0]      lk;
    logic [3:0]      thr_s;

    int errors = 0;
    int checks = 0;

    bsnn_lif_layer_if #(.WIDTH(8), .N_NEURONS(4), .POT_W(8), .T_STEPS(4)) if0 ();
    bsnn_lif_layer_if #(.WIDTH(8), .N_NEURONS(4), .POT_W(8), .T_STEPS(4)) if1 ();
    bsnn_lif_layer_if #(.WIDTH(8), .N_NEURONS(4), .POT_W(4), .T_STEPS(4)) if2 ();

    assign if0.in_valid = iv;   assign if1.in_valid = iv;   assign if2.in_valid = iv;
    assign if0.input_bits = bits; assign if1.input_bits = bits; assign if2.input_bits = bits;
    assign if0.weights = w;     assign if1.weights = w;     assign if2.weights = w;
    assign if0.threshold = thr; assign if1.threshold = thr; assign if2.threshold = thr_s;
    assign if0.leak = lk;       assign if1.leak = lk;       assign if2.leak = lk[3:0];
    assign if0.out_ready = ordy; assign if1.out_ready = ordy; assign if2.out_ready = ordy;

    bsnn_lif_layer #(.WIDTH(8), .N_NEURONS(4), .POT_W(8), .T_STEPS(4), .RESET_MODE(0))
        dut0 (.clk(clk), .rst(rst), .io(if0));
    bsnn_lif_layer #(.WIDTH(8), .N_NEURONS(4), .POT_W(8), .T_STEPS(4), .RESET_MODE(1))
        dut1 (.clk(clk), .rst(rst), .io(if1));
    bsnn_lif_layer #(.WIDTH(8), .N_NEURONS(4), .POT_W(4), .T_STEPS(4), .RESET_MODE(0))
        dut2 (.clk(clk), .rst(rst), .io(if2));

    // Observed word: {valid, spikes[3:0], step_idx[1:0], last, count[4x3], membrane[4x8]}
    logic [51:0]     obs [3];
    logic [3:0][7:0] m2;
    always_comb begin
        m2 = '0;
        for (int i = 0; i < 4; i++) m2[i] = {4'b0, if2.membrane[i]};
        obs[0] = {if0.out_valid, if0.spikes, if0.step_idx, if0.out_last, if0.spike_count, if0.membrane};
        obs[1] = {if1.out_valid, if1.spikes, if1.step_idx, if1.out_last, if1.spike_count, if1.membrane};
        obs[2] = {if2.out_valid, if2.spikes, if2.step_idx, if2.out_last, if2.spike_count, m2};
    end

    logic [51:0] exp_q [3][$];
    int          m_pot [3][4];
    int          m_cnt [3][4];
    int          m_step;
    logic        t_xfer, t_acc, t_spur;
    logic [51:0] t_got  [3];
    logic [51:0] t_want [3];
    logic [3:0]  spk_tab [4];

    // Reference: apply one timestep of the LIF rules to all three instances.
    task automatic model_accept(input logic [7:0] b);
        int pmax, th, lv, match, prev, s;
        bit rm, spk;
        logic [7:0] x;
        logic [3:0] sv;
        logic [3:0][2:0] cv;
        logic [3:0][7:0] mv;
        for (int d = 0; d < 3; d++) begin
            pmax = (d == 2) ? 15 : 255;
            th   = (d == 2) ? int'(thr_s) : int'(thr);
            lv   = (d == 2) ? int'(lk[3:0]) : int'(lk);
            rm   = (d == 1);
            for (int i = 0; i < 4; i++) begin
                x     = ~(b ^ w[i]);
                match = $countones(x);
                prev  = (m_step == 0) ? 0 : m_pot[d][i];
                s     = prev + match - lv;
                if (s < 0) s = 0;
                if (s > pmax) s = pmax;
                spk   = (s >= th);
                m_pot[d][i] = spk ? (rm ? 0 : s - th) : s;
                m_cnt[d][i] = ((m_step == 0) ? 0 : m_cnt[d][i]) + (spk ? 1 : 0);
                sv[i] = spk;
                cv[i] = 3'(m_cnt[d][i]);
                mv[i] = 8'(m_pot[d][i]);
            end
            exp_q[d].push_back({1'b1, sv, 2'(m_step), (m_step == 3), cv, mv});
        end
        m_step = (m_step == 3) ? 0 : m_step + 1;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++) exp_q[d].delete();
        m_step = 0;
    endtask

    // Drive one cycle at the falling edge; record the transfer about to happen and model any accept.
    task automatic tick(input logic v, input logic [7:0] b, input logic r);
        @(negedge clk);
        iv = v; bits = b; ordy = r;
        #1;
        t_xfer = if0.out_valid && r;
        t_acc  = v && if0.in_ready;
        t_spur = 1'b0;
        for (int d = 0; d < 3; d++) begin
            t_got[d]  = obs[d];
            t_want[d] = '0;
            if (t_xfer) begin
                if (exp_q[d].size() == 0) t_spur = 1'b1;
                else t_want[d] = exp_q[d].pop_front();
            end
        end
        if (t_acc) model_accept(b);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; iv = 1'b0; ordy = 1'b1; bits = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs[d] !== '0) begin
                errors++; $display("FAIL reset_outputs dut%0d: got %h want 0", d, obs[d]);
            end
        end
        checks++;
        if (if0.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", if0.in_ready);
        end
        clear_model();
    endtask

    task automatic test_basic();
        int sent = 0, seen = 0;
        w = {8'hFF, 8'h00, 8'hD4, 8'hD6}; thr = 8'd5; thr_s = 4'd5; lk = 8'd0;
        for (int c = 0; c < 40 && (sent < 4 || exp_q[0].size() != 0); c++) begin
            tick(sent < 4, 8'hD6, 1'b1);
            if (t_acc) sent++;
            if (t_xfer) for (int d = 0; d < 3; d++) begin
                checks++;
                if (t_spur || t_got[d] !== t_want[d]) begin
                    errors++; $display("FAIL stream_basic dut%0d: got %h want %h", d, t_got[d], t_want[d]);
                end
            end
            if (t_xfer && seen < 4) begin
                checks++;
                if (t_got[0][50:47] !== spk_tab[seen] || t_got[0][46:45] !== 2'(seen) ||
                    t_got[0][44] !== (seen == 3)) begin
                    errors++; $display("FAIL basic_step%0d: got spk=%b idx=%0d last=%b want spk=%b idx=%0d",
                                       seen, t_got[0][50:47], t_got[0][46:45], t_got[0][44], spk_tab[seen], seen);
                end
                if (seen == 3) begin
                    checks++;
                    if (t_got[0][31:0] !== {8'd0, 8'd2, 8'd8, 8'd12} ||
                        t_got[0][43:32] !== {3'd4, 3'd2, 3'd4, 3'd4}) begin
                        errors++; $display("FAIL basic_final: got mem=%h cnt=%h want mem=0002080c cnt={4,2,4,4}",
                                           t_got[0][31:0], t_got[0][43:32]);
                    end
                end
                seen++;
            end
        end
        checks++;
        if (seen != 4) begin errors++; $display("FAIL basic_timeout: got %0d steps want 4", seen); end
    endtask

    task automatic test_leak();
        int sent = 0, seen = 0;
        lk = 8'd2;
        for (int c = 0; c < 40 && (sent < 4 || exp_q[0].size() != 0); c++) begin
            tick(sent < 4, 8'hD6, 1'b1);
            if (t_acc) sent++;
            if (t_xfer) for (int d = 0; d < 3; d++) begin
                checks++;
                if (t_spur || t_got[d] !== t_want[d]) begin
                    errors++; $display("FAIL stream_leak dut%0d: got %h want %h", d, t_got[d], t_want[d]);
                end
            end
            if (t_xfer && seen == 0) begin
                checks++;
                if (t_got[0][50:47] !== 4'b0011 || t_got[0][31:0] !== {8'd3, 8'd1, 8'd0, 8'd1}) begin
                    errors++; $display("FAIL leak_step0: got spk=%b mem=%h want spk=0011 mem=03010001",
                                       t_got[0][50:47], t_got[0][31:0]);
                end
            end
            if (t_xfer) seen++;
        end
        checks++;
        if (seen != 4) begin errors++; $display("FAIL leak_timeout: got %0d steps want 4", seen); end
        lk = 8'd0;
    endtask

    task automatic test_reset_mode();
        int sent = 0, seen = 0;
        for (int c = 0; c < 40 && (sent < 4 || exp_q[1].size() != 0); c++) begin
            tick(sent < 4, 8'hD6, 1'b1);
            if (t_acc) sent++;
            if (t_xfer) for (int d = 0; d < 3; d++) begin
                checks++;
                if (t_spur || t_got[d] !== t_want[d]) begin
                    errors++; $display("FAIL stream_rmode dut%0d: got %h want %h", d, t_got[d], t_want[d]);
                end
            end
            if (t_xfer && seen == 0) begin
                checks++;
                if (t_got[1][50:47] !== 4'b1011 || t_got[1][31:0] !== {8'd0, 8'd3, 8'd0, 8'd0}) begin
                    errors++; $display("FAIL rmode_step0: got spk=%b mem=%h want spk=1011 mem=00030000",
                                       t_got[1][50:47], t_got[1][31:0]);
                end
            end
            if (t_xfer) seen++;
        end
        checks++;
        if (seen != 4) begin errors++; $display("FAIL rmode_timeout: got %0d steps want 4", seen); end
    endtask

    task automatic test_backpressure();
        int sent = 0, seen = 0;
        logic r;
        logic [51:0] snap;
        snap = '0;
        for (int c = 0; c < 40 && (sent < 4 || exp_q[0].size() != 0); c++) begin
            r = !(c >= 3 && c < 6);
            tick(sent < 4, 8'hD6, r);
            if (t_acc) sent++;
            if (t_xfer) for (int d = 0; d < 3; d++) begin
                checks++;
                if (t_spur || t_got[d] !== t_want[d]) begin
                    errors++; $display("FAIL stream_bp dut%0d: got %h want %h", d, t_got[d], t_want[d]);
                end
            end
            if (t_xfer) seen++;
            if (c == 3) snap = obs[0];
            if (c >= 3 && c < 6) begin
                checks++;
                if (if0.in_ready !== 1'b0 || if0.out_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_handshake c%0d: got in_ready=%b out_valid=%b want 0/1",
                                       c, if0.in_ready, if0.out_valid);
                end
            end
            if (c >= 4 && c <= 6) begin
                checks++;
                if (obs[0] !== snap) begin
                    errors++; $display("FAIL bp_hold c%0d: got %h want %h", c, obs[0], snap);
                end
            end
        end
        checks++;
        if (seen != 4) begin errors++; $display("FAIL bp_timeout: got %0d steps want 4", seen); end
    endtask

    task automatic test_saturation();
        int sent = 0, seen = 0;
        w = {4{8'hD6}}; thr_s = 4'd15;
        for (int c = 0; c < 40 && (sent < 4 || exp_q[2].size() != 0); c++) begin
            tick(sent < 4, 8'hD6, 1'b1);
            if (t_acc) sent++;
            if (t_xfer) for (int d = 0; d < 3; d++) begin
                checks++;
                if (t_spur || t_got[d] !== t_want[d]) begin
                    errors++; $display("FAIL stream_sat dut%0d: got %h want %h", d, t_got[d], t_want[d]);
                end
            end
            if (t_xfer && seen == 0) begin
                checks++;
                if (t_got[2][50:47] !== 4'b0000 || t_got[2][31:0] !== {4{8'd8}}) begin
                    errors++; $display("FAIL sat_step0: got spk=%b mem=%h want spk=0000 mem=08080808",
                                       t_got[2][50:47], t_got[2][31:0]);
                end
            end
            if (t_xfer && seen == 1) begin
                checks++;
                if (t_got[2][50:47] !== 4'b1111 || t_got[2][31:0] !== 32'd0) begin
                    errors++; $display("FAIL sat_step1: got spk=%b mem=%h want spk=1111 mem=0",
                                       t_got[2][50:47], t_got[2][31:0]);
                end
            end
            if (t_xfer) seen++;
        end
        checks++;
        if (seen != 4) begin errors++; $display("FAIL sat_timeout: got %0d steps want 4", seen); end
        thr_s = 4'd5;
    endtask

    task automatic test_mid_reset();
        int sent = 0, seen = 0;
        w = {8'hFF, 8'h00, 8'hD4, 8'hD6};
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 8'hD6, 1'b1);
            if (t_xfer) for (int d = 0; d < 3; d++) begin
                checks++;
                if (t_spur || t_got[d] !== t_want[d]) begin
                    errors++; $display("FAIL stream_prerst dut%0d: got %h want %h", d, t_got[d], t_want[d]);
                end
            end
        end
        @(negedge clk);
        rst = 1'b1; iv = 1'b1; ordy = 1'b1;
        @(negedge clk);
        rst = 1'b0; iv = 1'b0;
        #1;
        clear_model();
        checks++;
        if (if0.out_valid !== 1'b0 || if2.out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_valid: got %b%b want 00", if0.out_valid, if2.out_valid);
        end
        for (int c = 0; c < 40 && (sent < 4 || exp_q[0].size() != 0); c++) begin
            tick(sent < 4 && c >= 2, 8'hD6, 1'b1);
            if (t_acc) sent++;
            if (t_xfer) for (int d = 0; d < 3; d++) begin
                checks++;
                if (t_spur || t_got[d] !== t_want[d]) begin
                    errors++; $display("FAIL stream_midrst dut%0d: got %h want %h", d, t_got[d], t_want[d]);
                end
            end
            if (t_xfer && seen < 4) begin
                checks++;
                if (t_got[0][50:47] !== spk_tab[seen] || t_got[0][46:45] !== 2'(seen)) begin
                    errors++; $display("FAIL midrst_step%0d: got spk=%b idx=%0d want spk=%b idx=%0d",
                                       seen, t_got[0][50:47], t_got[0][46:45], spk_tab[seen], seen);
                end
                seen++;
            end
        end
        checks++;
        if (seen != 4) begin errors++; $display("FAIL midrst_timeout: got %0d steps want 4", seen); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int sent = 0;
            for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
            thr   = (f == 0) ? 8'd0 : 8'($urandom_range(0, 20));
            thr_s = 4'($urandom_range(0, 15));
            lk    = 8'($urandom_range(0, 4));
            for (int c = 0; c < 200 && (sent < 4 || exp_q[0].size() != 0); c++) begin
                tick(sent < 4 && $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
                if (t_acc) sent++;
                if (t_xfer) for (int d = 0; d < 3; d++) begin
                    checks++;
                    if (t_spur || t_got[d] !== t_want[d]) begin
                        errors++; $display("FAIL stream_rand f%0d dut%0d: got %h want %h", f, d, t_got[d], t_want[d]);
                    end
                end
                if (t_xfer && f == 0) begin
                    checks++;
                    if (t_got[0][50:47] !== 4'b1111) begin
                        errors++; $display("FAIL rand_thr0: got spk=%b want 1111", t_got[0][50:47]);
                    end
                end
            end
            checks++;
            if (sent != 4 || exp_q[0].size() != 0) begin
                errors++; $display("FAIL rand_timeout f%0d: got sent=%0d pending=%0d want 4/0",
                                   f, sent, exp_q[0].size());
            end
        end
    endtask

    initial begin
        rst = 1'b1; iv = 1'b0; ordy = 1'b1; bits = '0;
        w = '0; thr = 8'd5; thr_s = 4'd5; lk = 8'd0;
        m_step = 0;
        spk_tab[0] = 4'b1011; spk_tab[1] = 4'b1111; spk_tab[2] = 4'b1011; spk_tab[3] = 4'b1111;
        test_reset();
        test_basic();
        test_leak();
        test_reset_mode();
        test_backpressure();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
